deal_sequencer: RTL

//  Round controller for the blackjack datapath. Owns the single card_rng output and shares it between player and dealer draws.

---
 rtl/deal_sequencer_pkg.sv | 30 +++
 rtl/deal_sequencer_hand.sv | 37 +++
 rtl/deal_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/deal_sequencer_pkg.sv
// deal_sequencer_pkg: state encodings, phase codes and card/total helpers shared by the round controller
package deal_sequencer_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2,
        S_PLAYER_TURN, S_PLAYER_DRAW, S_DEALER_TURN, S_DEALER_DRAW, S_RESULT
    } state_t;
    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_DEAL   = 3'd1;
    localparam logic [2:0] PH_PLAYER = 3'd2;
    localparam logic [2:0] PH_DEALER = 3'd3;
    localparam logic [2:0] PH_PWIN   = 3'd4;
    localparam logic [2:0] PH_DWIN   = 3'd5;
    localparam logic [2:0] PH_PUSH   = 3'd6;
    function automatic logic card_valid(input logic [3:0] v);
        return v != 4'd0 && v <= 4'd13;
    endfunction
    function automatic logic [4:0] card_pts(input logic [3:0] v);
        return (v >= 4'd10) ? 5'd10 : {1'b0, v};
    endfunction
    // A held ace is promoted to 11 whenever that does not bust the hand.
    function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction
    function automatic logic [2:0] phase_of(input state_t s, input logic [2:0] res);
        return (s == S_IDLE) ? PH_IDLE :
               (s == S_RESULT) ? res :
               (s inside {S_PLAYER_TURN, S_PLAYER_DRAW}) ? PH_PLAYER :
               (s inside {S_DEALER_TURN, S_DEALER_DRAW}) ? PH_DEALER : PH_DEAL;
    endfunction
endpackage

// File: rtl/deal_sequencer_hand.sv
// deal_sequencer_hand: one hand's hard total, ace flag and first-card total
//   clr_i/add_i      clear the hand / add the presented card
//   pts_i/ace_i      points and ace flag of the presented card
//   best_o           best total of the current hand
//   next_best_o      best total the hand would have with the presented card added
//   first_o          best total of the first card alone (dealer hidden view)
module deal_sequencer_hand
    import deal_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [4:0] pts_i,
    input  logic       ace_i,
    output logic [4:0] best_o,
    output logic [4:0] next_best_o,
    output logic [4:0] first_o
);
    logic [4:0] hard_q;
    logic       ace_q;
    logic [4:0] first_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            hard_q  <= 5'd0;
            ace_q   <= 1'b0;
            first_q <= 5'd0;
        end else if (add_i) begin
            hard_q  <= hard_q + pts_i;
            ace_q   <= ace_q | ace_i;
            if (hard_q == 5'd0) first_q <= best_total(pts_i, ace_i);
        end
    end
    assign best_o      = best_total(hard_q, ace_q);
    assign next_best_o = best_total(hard_q + pts_i, ace_q | ace_i);
    assign first_o     = first_q;
endmodule

// File: rtl/deal_sequencer.sv
// deal_sequencer: blackjack round controller sharing one card source between player and dealer
//   key_*_n          raw active-low buttons, synchronised and edge-detected here
//   card_value       free-running card source, 1..13 valid
//   player_score     player best total
//   dealer_score     dealer best total, first card only while dealer_hidden
//   dealer_hidden    dealer hole card concealed
//   game_phase       0 idle, 1 deal, 2 player, 3 dealer, 4 P win, 5 D win, 6 push
//   card_taken       one-cycle pulse per accepted card
module deal_sequencer
    import deal_sequencer_pkg::*;
#(
    parameter int DEALER_STAND  = 17,
    parameter int BUST_LIMIT    = 21,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_hit_n,
    input  logic       key_stand_n,
    input  logic       key_deal_n,
    input  logic [3:0] card_value,
    output logic [4:0] player_score,
    output logic [4:0] dealer_score,
    output logic       dealer_hidden,
    output logic [2:0] game_phase,
    output logic       card_taken
);
    localparam logic [4:0] STAND  = 5'(DEALER_STAND);
    localparam logic [4:0] BUST   = 5'(BUST_LIMIT);
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
    state_t     state_q;
    logic [3:0] settle_q;
    logic [2:0] res_q;
    logic [2:0] s1_q, s2_q, s3_q, pulse_q;
    logic [4:0] p_best, p_next, p_first, d_best, d_next, d_first;
    logic       draw, to_player, take, clr, hid, hit_p, stand_p, deal_p;
    // Bit order {deal, stand, hit}; idle-high so reset never fakes a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '1;
            s2_q    <= '1;
            s3_q    <= '1;
            pulse_q <= '0;
        end else begin
            s1_q    <= {key_deal_n, key_stand_n, key_hit_n};
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= s3_q & ~s2_q;
        end
    end
    assign hit_p     = pulse_q[0];
    assign stand_p   = pulse_q[1];
    assign deal_p    = pulse_q[2];
    assign draw      = state_q inside {S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_PLAYER_DRAW, S_DEALER_DRAW};
    assign to_player = state_q inside {S_DEAL_P1, S_DEAL_P2, S_PLAYER_DRAW};
    assign take      = draw && settle_q == 4'd0 && card_valid(card_value);
    assign clr       = deal_p && (state_q == S_IDLE || state_q == S_RESULT);
    assign hid       = state_q inside {S_DEAL_D2, S_PLAYER_TURN, S_PLAYER_DRAW};
    deal_sequencer_hand u_player (
        .clk(clk), .rst(rst), .clr_i(clr), .add_i(take && to_player),
        .pts_i(card_pts(card_value)), .ace_i(card_value == 4'd1),
        .best_o(p_best), .next_best_o(p_next), .first_o(p_first)
    );
    deal_sequencer_hand u_dealer (
        .clk(clk), .rst(rst), .clr_i(clr), .add_i(take && !to_player),
        .pts_i(card_pts(card_value)), .ace_i(card_value == 4'd1),
        .best_o(d_best), .next_best_o(d_next), .first_o(d_first)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            settle_q      <= 4'd0;
            res_q         <= PH_IDLE;
            player_score  <= 5'd0;
            dealer_score  <= 5'd0;
            dealer_hidden <= 1'b0;
            game_phase    <= PH_IDLE;
            card_taken    <= 1'b0;
        end else begin
            player_score  <= p_best;
            dealer_score  <= hid ? d_first : d_best;
            dealer_hidden <= hid;
            game_phase    <= phase_of(state_q, res_q);
            card_taken    <= take;
            if (draw && settle_q != 4'd0) settle_q <= settle_q - 4'd1;
            case (state_q)
                S_IDLE, S_RESULT: if (deal_p) begin
                    state_q  <= S_DEAL_P1;
                    settle_q <= SETTLE;
                end
                S_DEAL_P1: if (take) begin
                    state_q  <= S_DEAL_D1;
                    settle_q <= SETTLE;
                end
                S_DEAL_D1: if (take) begin
                    state_q  <= S_DEAL_P2;
                    settle_q <= SETTLE;
                end
                S_DEAL_P2: if (take) begin
                    state_q  <= S_DEAL_D2;
                    settle_q <= SETTLE;
                end
                S_DEAL_D2: if (take) state_q <= (p_best == 5'd21) ? S_DEALER_TURN : S_PLAYER_TURN;
                S_PLAYER_TURN: begin
                    if (stand_p) state_q <= S_DEALER_TURN;
                    else if (hit_p && p_best < BUST) begin
                        state_q  <= S_PLAYER_DRAW;
                        settle_q <= SETTLE;
                    end
                end
                // Decide on the total including the card being accepted this cycle.
                S_PLAYER_DRAW: if (take) begin
                    state_q <= (p_next > BUST) ? S_RESULT : (p_next == 5'd21) ? S_DEALER_TURN : S_PLAYER_TURN;
                    res_q   <= PH_DWIN;
                end
                S_DEALER_TURN: begin
                    if (d_best >= STAND) begin
                        state_q <= S_RESULT;
                        res_q   <= (d_best > BUST || p_best > d_best) ? PH_PWIN :
                                   (p_best < d_best) ? PH_DWIN : PH_PUSH;
                    end else begin
                        state_q  <= S_DEALER_DRAW;
                        settle_q <= SETTLE;
                    end
                end
                S_DEALER_DRAW: if (take) state_q <= S_DEALER_TURN;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
